// File: rtl/periph_tx_arbiter_pkg.sv
// Shared Lycan constants and the TX arbiter state type.
// The arbiter and the round-robin picker import this package.
package lycan_globals;

  localparam int num_peripherals      = 2;
  localparam int periph_address_width = 3;
  localparam int usb_packet_width     = 32;
  localparam int max_burst            = 4;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/periph_tx_arbiter_if.sv
// Bundles the per-slot request streams and the single USB TX output stream.
// The master modport is the arbiter side; the slave modport is the environment side.
interface periph_tx_arbiter_if
  import lycan_globals::*;
#(
  parameter int NUM_PERIPH = num_peripherals,
  parameter int DATA_W     = usb_packet_width,
  parameter int ADDR_W     = periph_address_width
);

  logic [NUM_PERIPH-1:0]        periph_enable;
  logic [NUM_PERIPH*DATA_W-1:0] in_data;
  logic [NUM_PERIPH-1:0]        in_valid;
  logic [NUM_PERIPH-1:0]        in_ready;
  logic [DATA_W-1:0]            out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [ADDR_W-1:0]            grant_idx;

  modport master (
    input  periph_enable, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, grant_idx
  );

  modport slave (
    output periph_enable, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, grant_idx
  );

endinterface

// File: rtl/periph_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: the first requester after 'last', wrapping modulo NUM_PERIPH.
// It is kept free of arbiter state so that other schedulers can reuse it.
module rr_pick
  import lycan_globals::*;
#(
  parameter int NUM_PERIPH = num_peripherals,
  parameter int ADDR_W     = periph_address_width
) (
  input  logic [NUM_PERIPH-1:0] req,
  input  logic [ADDR_W-1:0]     last,
  output logic                  hit,
  output logic [ADDR_W-1:0]     idx
);

  // Walk candidates last+1 .. last+NUM_PERIPH; the first requester wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = 1; k <= NUM_PERIPH; k++) begin
      int   cand;
      logic take;
      cand = (int'(last) + k) % NUM_PERIPH;
      for (int i = 0; i < NUM_PERIPH; i++) begin
        take = !hit && req[i] && (cand == i);
        idx  = take ? ADDR_W'(i) : idx;
        hit  = hit | take;
      end
    end
  end

endmodule

// File: rtl/periph_tx_arbiter.sv
// Round-robin, burst-bounded arbiter that merges peripheral packet streams into one USB TX stream.
// The arbiter replaces the top ADDR_W bits of each packet with the index of the granted slot.
module periph_tx_arbiter
  import lycan_globals::*;
#(
  parameter int NUM_PERIPH = num_peripherals,
  parameter int ADDR_W     = periph_address_width,
  parameter int DATA_W     = usb_packet_width,
  parameter int MAX_BURST  = max_burst
) (
  input logic                 clk,
  input logic                 rst,
  periph_tx_arbiter_if.master bus
);

  localparam int BURST_W   = $clog2(MAX_BURST + 1);
  localparam int PAYLOAD_W = DATA_W - ADDR_W;

  arb_state_t              state_r;
  logic [BURST_W-1:0]      burst_cnt_r;
  logic [ADDR_W-1:0]       last_grant_r;
  logic [ADDR_W-1:0]       grant_r;
  logic [DATA_W-1:0]       out_data_r;
  logic                    out_valid_r;

  logic                    slot_free_s;
  logic                    grant_valid_s;
  logic                    xfer_s;
  logic                    pick_hit_s;
  logic [ADDR_W-1:0]       pick_idx_s;
  logic [DATA_W-1:0]       grant_data_s;
  logic [NUM_PERIPH-1:0]   in_ready_s;

  rr_pick #(
    .NUM_PERIPH (NUM_PERIPH),
    .ADDR_W     (ADDR_W)
  ) u_rr_pick (
    .req  (bus.in_valid & bus.periph_enable),
    .last (last_grant_r),
    .hit  (pick_hit_s),
    .idx  (pick_idx_s)
  );

  // Select the granted slot's request and compute the accept strobe from registered state.
  always_comb begin
    slot_free_s   = !out_valid_r || bus.out_ready;
    grant_valid_s = 1'b0;
    grant_data_s  = '0;
    in_ready_s    = '0;
    for (int i = 0; i < NUM_PERIPH; i++) begin
      logic sel;
      sel           = (grant_r == ADDR_W'(i));
      in_ready_s[i] = (state_r == GRANT) && sel && slot_free_s;
      grant_valid_s = grant_valid_s | (sel && bus.in_valid[i]);
      grant_data_s  = grant_data_s | ({DATA_W{sel}} & bus.in_data[i*DATA_W +: DATA_W]);
    end
    xfer_s = (state_r == GRANT) && grant_valid_s && slot_free_s;
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.grant_idx = grant_r;

  // Output register and arbitration FSM; ARB spends exactly one cycle and never transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ARB;
      burst_cnt_r  <= '0;
      last_grant_r <= ADDR_W'(NUM_PERIPH - 1);
      grant_r      <= '0;
      out_data_r   <= '0;
      out_valid_r  <= 1'b0;
    end else begin
      if (xfer_s) begin
        out_data_r  <= {grant_r, grant_data_s[PAYLOAD_W-1:0]};
        out_valid_r <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end

      case (state_r)
        ARB: begin
          if (pick_hit_s) begin
            grant_r     <= pick_idx_s;
            burst_cnt_r <= '0;
            state_r     <= GRANT;
          end
        end
        GRANT: begin
          if (xfer_s) begin
            if (burst_cnt_r == BURST_W'(MAX_BURST - 1)) begin
              last_grant_r <= grant_r;
              state_r      <= ARB;
            end else begin
              burst_cnt_r <= burst_cnt_r + BURST_W'(1);
            end
          end else if (!grant_valid_s) begin
            // Requester ran dry: release the grant early.
            last_grant_r <= grant_r;
            state_r      <= ARB;
          end
        end
        default: state_r <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_tx_arbiter.sv
// Scoreboard bench for periph_tx_arbiter: per-slot source queues, expected-output queue and an output monitor.
module tb_periph_tx_arbiter;
  import lycan_globals::*;

  localparam int NP = 2;
  localparam int AW = 3;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  periph_tx_arbiter_if #(.NUM_PERIPH(NP), .DATA_W(DW), .ADDR_W(AW)) bus ();

  periph_tx_arbiter #(
    .NUM_PERIPH (NP),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .MAX_BURST  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks   = 0;
  int          n_pass     = 0;
  int          xfer_count = 0;
  int          cyc        = 0;
  int          stamp [256];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] exp_q [$];
  logic [1:0]  acc        = 2'b00;
  logic        ready_val  = 1'b1;
  logic [1:0]  en_val     = 2'b11;
  bit          chk_grant  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Source driver: pops accepted packets, presents queue heads, applies ready/enable controls.
  initial begin
    bus.in_valid      = 2'b00;
    bus.in_data       = '0;
    bus.out_ready     = 1'b1;
    bus.periph_enable = 2'b11;
    forever begin
      @(negedge clk);
      if (acc[0] && q0.size() > 0) void'(q0.pop_front());
      if (acc[1] && q1.size() > 0) void'(q1.pop_front());
      if (q0.size() > 0) begin bus.in_valid[0] = 1'b1; bus.in_data[31:0] = q0[0]; end
      else begin bus.in_valid[0] = 1'b0; bus.in_data[31:0] = 32'h0; end
      if (q1.size() > 0) begin bus.in_valid[1] = 1'b1; bus.in_data[63:32] = q1[0]; end
      else begin bus.in_valid[1] = 1'b0; bus.in_data[63:32] = 32'h0; end
      bus.out_ready     = ready_val;
      bus.periph_enable = en_val;
      #1;
      acc = bus.in_valid & bus.in_ready;
    end
  end

  // Output monitor: every accepted output packet is compared against the head of the scoreboard.
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    #2;
    cyc++;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out: got 0x%08h, expected no output", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", bus.out_data, e);
        if (chk_grant) check("grant_idx", 32'(bus.grant_idx), 32'(e[31:29]));
      end
      stamp[xfer_count & 255] = cyc;
      xfer_count++;
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin @(posedge clk); k++; end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_xfers(input string name, input int target, input int budget);
    int k = 0;
    while (xfer_count < target && k < budget) begin @(posedge clk); k++; end
    check(name, 32'(xfer_count >= target), 32'd1);
  endtask

  task automatic do_reset(input bit clear);
    @(posedge clk);
    if (clear) begin q0.delete(); q1.delete(); end
    @(negedge clk); #3; rst = 1'b1;
    @(negedge clk); #3; rst = 1'b0;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  bus.out_data,        32'd0);
    check("rst_in_ready",  32'(bus.in_ready),   32'd0);
    check("rst_grant_idx", 32'(bus.grant_idx),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int k;
    do_reset(1'b1);

    // Single busy slot: bursts of 4 separated by one arbitration bubble.
    chk_grant = 1'b1;
    base = xfer_count;
    @(posedge clk);
    for (int i = 1; i <= 6; i++) begin q0.push_back(32'(i)); exp_q.push_back(32'(i)); end
    wait_drain("t1_drain", 100);
    check("t1_burst_span", 32'(stamp[base + 3] - stamp[base]),     32'd3);
    check("t1_bubble",     32'(stamp[base + 4] - stamp[base + 3]), 32'd2);
    check("t1_after",      32'(stamp[base + 5] - stamp[base + 4]), 32'd1);

    // Two busy slots alternate in bursts of 4; slot bits overwrite the top of the packet.
    do_reset(1'b1);
    @(posedge clk);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        q0.push_back(32'hE000_0100 + 32'(r * 4 + i));
        q1.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0000_0100 + 32'(r * 4 + i));
      end
      for (int i = 0; i < 4; i++) exp_q.push_back(32'h3FFF_FFFF);
    end
    wait_drain("t2_drain", 200);

    // Backpressure mid-burst: output held, no accepts, nothing lost or duplicated.
    chk_grant = 1'b0;
    base = xfer_count;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin q0.push_back(32'h200 + 32'(i)); exp_q.push_back(32'h200 + 32'(i)); end
    wait_xfers("t3_start", base + 2, 100);
    ready_val = 1'b0;
    @(negedge clk); #3;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); #3; end
      check("t3_bp_in_ready",  32'(bus.in_ready),  32'd0);
      check("t3_bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("t3_bp_out_data",  bus.out_data, (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF);
    end
    check("t3_bp_no_xfer", 32'(xfer_count), 32'(base + 2));
    @(posedge clk);
    ready_val = 1'b1;
    wait_drain("t3_drain", 200);

    // Enable mask: slot 1 never granted; clearing slot 0 mid-burst lets the burst finish.
    base = xfer_count;
    @(posedge clk);
    en_val = 2'b01;
    for (int i = 0; i < 6; i++) q0.push_back(32'h40 + 32'(i));
    for (int i = 0; i < 3; i++) q1.push_back(32'h50 + 32'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h40 + 32'(i));
    wait_xfers("t4_start", base + 1, 100);
    en_val = 2'b00;
    wait_drain("t4_drain", 100);
    repeat (20) @(posedge clk);
    @(negedge clk); #3;
    check("t4_count",     32'(xfer_count),    32'(base + 4));
    check("t4_out_valid", 32'(bus.out_valid), 32'd0);
    check("t4_in_ready",  32'(bus.in_ready),  32'd0);

    // Requester runs dry after 2 packets; the next grant goes to slot 0.
    do_reset(1'b1);
    en_val    = 2'b11;
    chk_grant = 1'b1;
    @(posedge clk);
    q1.push_back(32'h60); q1.push_back(32'h61);
    exp_q.push_back(32'h2000_0060); exp_q.push_back(32'h2000_0061);
    wait_drain("t5_dry_drain", 100);
    @(posedge clk);
    q0.push_back(32'h70); q1.push_back(32'h62);
    exp_q.push_back(32'h0000_0070); exp_q.push_back(32'h2000_0062);
    wait_drain("t5_next_drain", 100);

    // Reset while a packet is stalled: it is dropped and the search restarts at slot 0.
    chk_grant = 1'b0;
    @(posedge clk);
    ready_val = 1'b0;
    q1.push_back(32'h80); q1.push_back(32'h81);
    k = 0;
    while (bus.out_valid !== 1'b1 && k < 50) begin @(negedge clk); #3; k++; end
    check("t6_stalled", 32'(bus.out_valid), 32'd1);
    q0.push_back(32'h90);
    do_reset(1'b0);
    exp_q.push_back(32'h0000_0090); exp_q.push_back(32'h2000_0081);
    ready_val = 1'b1;
    wait_drain("t6_drain", 100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
